// File: rtl/reflet_timer.sv
// Memory-mapped countdown timer for the reflet CPU bus: prescaler, one-shot or
// auto-reload countdown, pending flag and level interrupt. Read data is zero when idle.
module reflet_timer #(
   parameter int wordsize = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [1:0]          addr,
   input  logic [wordsize-1:0] data_in,
   input  logic                write_en,
   output logic [wordsize-1:0] data_out,
   output logic                interrupt
);

   localparam logic [wordsize-1:0] ONE = {{(wordsize-1){1'b0}}, 1'b1};

   logic                run, auto_reload, irq_en, pending;
   logic [wordsize-1:0] prescale, reload, count, pcnt;

   logic                run_next, auto_reload_next, irq_en_next, pending_next;
   logic [wordsize-1:0] prescale_next, reload_next, count_next, pcnt_next;
   logic [wordsize-1:0] read_next;
   logic                interrupt_next;
   logic                tick, underflow;

   // >= rather than == so a PRESCALE lowered below pcnt mid-count ticks at once
   assign tick      = run && (pcnt >= prescale);
   assign underflow = tick && (count == '0);

   // Timer events are applied first; CPU writes then override them, except that
   // an underflow's PENDING set beats a same-cycle write-1-clear.
   always_comb begin
      run_next         = run;
      auto_reload_next = auto_reload;
      irq_en_next      = irq_en;
      pending_next     = pending;
      prescale_next    = prescale;
      reload_next      = reload;
      count_next       = count;
      pcnt_next        = (run && !tick) ? pcnt + ONE : '0;
      read_next        = '0;

      if (tick) begin
         if (count != '0) begin
            count_next = count - ONE;
         end else begin
            pending_next = 1'b1;
            if (auto_reload)
               count_next = reload;
            else
               run_next = 1'b0;
         end
      end

      if (enable && write_en) begin
         case (addr)
            2'd0: begin
               run_next         = data_in[0];
               auto_reload_next = data_in[1];
               irq_en_next      = data_in[2];
               if (data_in[3] && !underflow)
                  pending_next = 1'b0;
            end
            2'd1: prescale_next = data_in;
            2'd2: reload_next   = data_in;
            2'd3: count_next    = data_in;
         endcase
      end

      if (enable && !write_en) begin
         case (addr)
            2'd0: read_next = {{(wordsize-4){1'b0}}, pending, irq_en, auto_reload, run};
            2'd1: read_next = prescale;
            2'd2: read_next = reload;
            2'd3: read_next = count;
         endcase
      end

      interrupt_next = pending_next & irq_en_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         run         <= 1'b0;
         auto_reload <= 1'b0;
         irq_en      <= 1'b0;
         pending     <= 1'b0;
         prescale    <= '0;
         reload      <= '0;
         count       <= '0;
         pcnt        <= '0;
         data_out    <= '0;
         interrupt   <= 1'b0;
      end else begin
         run         <= run_next;
         auto_reload <= auto_reload_next;
         irq_en      <= irq_en_next;
         pending     <= pending_next;
         prescale    <= prescale_next;
         reload      <= reload_next;
         count       <= count_next;
         pcnt        <= pcnt_next;
         data_out    <= read_next;
         interrupt   <= interrupt_next;
      end
   end

endmodule

// File: tb/tb_reflet_timer.sv
// Directed testbench for reflet_timer: register vector table plus hand-written
// sequences for one-shot, auto-reload period and same-cycle collisions.
module tb_reflet_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [1:0]  addr;
   logic [15:0] data_in;
   logic        write_en;
   logic [15:0] data_out;
   logic        interrupt;

   int testsRun = 0;
   int testsFailed = 0;

   typedef struct {
      logic        en;
      logic        we;
      logic [1:0]  addr;
      logic [15:0] din;
      logic [15:0] expData;
      logic        expIrq;
   } vec_t;

   vec_t vectors[13];

   reflet_timer #(.wordsize(16)) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .addr(addr),
      .data_in(data_in),
      .write_en(write_en),
      .data_out(data_out),
      .interrupt(interrupt)
   );

   always #5 clk = ~clk;

   // One bus cycle: drive on the falling edge, return 1 time unit after the rising edge
   task automatic applyStimulus(input logic en, input logic we, input logic [1:0] a,
                                input logic [15:0] d);
      @(negedge clk);
      enable   = en;
      write_en = we;
      addr     = a;
      data_in  = d;
      @(posedge clk);
      #1;
      enable   = 1'b0;
      write_en = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset data_out", data_out, 16'h0000);
      checkOutput("reset interrupt", {15'b0, interrupt}, 16'h0000);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      enable   = 1'b0;
      write_en = 1'b0;
      addr     = 2'd0;
      data_in  = 16'h0000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Arbitrary state, then reset must clear every register
      applyStimulus(1'b1, 1'b1, 2'd1, 16'h0055);
      applyStimulus(1'b1, 1'b1, 2'd2, 16'h0AAA);
      applyStimulus(1'b1, 1'b1, 2'd3, 16'h0123);
      applyStimulus(1'b1, 1'b1, 2'd0, 16'h0007);
      doReset();
      for (int r = 0; r < 4; r++) begin
         applyStimulus(1'b1, 1'b0, r[1:0], 16'h0000);
         checkOutput($sformatf("reset reg%0d", r), data_out, 16'h0000);
      end
      checkOutput("reset irq after reads", {15'b0, interrupt}, 16'h0000);

      // Register access with the timer stopped
      vectors[0]  = '{1'b1, 1'b1, 2'd1, 16'hABCD, 16'h0000, 1'b0};
      vectors[1]  = '{1'b1, 1'b1, 2'd2, 16'h1234, 16'h0000, 1'b0};
      vectors[2]  = '{1'b1, 1'b0, 2'd2, 16'h0000, 16'h1234, 1'b0};
      vectors[3]  = '{1'b0, 1'b0, 2'd2, 16'h0000, 16'h0000, 1'b0};
      vectors[4]  = '{1'b1, 1'b0, 2'd1, 16'h0000, 16'hABCD, 1'b0};
      vectors[5]  = '{1'b1, 1'b1, 2'd3, 16'h00FF, 16'h0000, 1'b0};
      vectors[6]  = '{1'b1, 1'b0, 2'd3, 16'h0000, 16'h00FF, 1'b0};
      vectors[7]  = '{1'b1, 1'b1, 2'd0, 16'hFFF6, 16'h0000, 1'b0};
      vectors[8]  = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h0006, 1'b0};
      vectors[9]  = '{1'b1, 1'b1, 2'd1, 16'h0002, 16'h0000, 1'b0};
      vectors[10] = '{1'b1, 1'b0, 2'd1, 16'h0000, 16'h0002, 1'b0};
      vectors[11] = '{1'b1, 1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0};
      vectors[12] = '{1'b1, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0};
      for (int v = 0; v < 13; v++) begin
         applyStimulus(vectors[v].en, vectors[v].we, vectors[v].addr, vectors[v].din);
         checkOutput($sformatf("vec%0d data_out", v), data_out, vectors[v].expData);
         checkOutput($sformatf("vec%0d interrupt", v), {15'b0, interrupt},
                     {15'b0, vectors[v].expIrq});
      end

      // One-shot: PRESCALE=0, COUNT=3, RUN+IRQ_EN -> interrupt 4 cycles after the write
      doReset();
      applyStimulus(1'b1, 1'b1, 2'd3, 16'h0003);
      applyStimulus(1'b1, 1'b1, 2'd0, 16'h0005);
      idleCycles(3);
      checkOutput("oneshot irq early", {15'b0, interrupt}, 16'h0000);
      idleCycles(1);
      checkOutput("oneshot irq rise", {15'b0, interrupt}, 16'h0001);
      applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000);
      checkOutput("oneshot ctrl", data_out, 16'h000C);
      applyStimulus(1'b1, 1'b0, 2'd3, 16'h0000);
      checkOutput("oneshot count", data_out, 16'h0000);
      applyStimulus(1'b1, 1'b1, 2'd0, 16'h000C);
      checkOutput("oneshot irq clear", {15'b0, interrupt}, 16'h0000);

      // Auto-reload: PRESCALE=2, RELOAD=4, COUNT=0 -> underflows at edges 3 and 18
      doReset();
      applyStimulus(1'b1, 1'b1, 2'd1, 16'h0002);
      applyStimulus(1'b1, 1'b1, 2'd2, 16'h0004);
      applyStimulus(1'b1, 1'b1, 2'd0, 16'h0003);
      idleCycles(3);
      applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000);
      checkOutput("auto first pending", data_out, 16'h000B);
      applyStimulus(1'b1, 1'b1, 2'd0, 16'h000B);
      idleCycles(12);
      applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000);
      checkOutput("auto before period", data_out, 16'h0003);
      applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000);
      checkOutput("auto at period", data_out, 16'h000B);
      applyStimulus(1'b1, 1'b0, 2'd3, 16'h0000);
      checkOutput("auto reloaded count", data_out, 16'h0004);
      checkOutput("auto irq masked", {15'b0, interrupt}, 16'h0000);

      // COUNT write on a tick cycle: the written value wins
      doReset();
      applyStimulus(1'b1, 1'b1, 2'd3, 16'h0064);
      applyStimulus(1'b1, 1'b1, 2'd0, 16'h0001);
      applyStimulus(1'b1, 1'b1, 2'd3, 16'h0007);
      applyStimulus(1'b1, 1'b0, 2'd3, 16'h0000);
      checkOutput("count write vs tick", data_out, 16'h0007);
      applyStimulus(1'b1, 1'b1, 2'd0, 16'h0000);

      // Write-1-clear and RUN=1 on the one-shot underflow cycle
      doReset();
      applyStimulus(1'b1, 1'b1, 2'd3, 16'h0001);
      applyStimulus(1'b1, 1'b1, 2'd0, 16'h0005);
      idleCycles(1);
      applyStimulus(1'b1, 1'b1, 2'd0, 16'h000D);
      checkOutput("clear vs underflow irq", {15'b0, interrupt}, 16'h0001);
      applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000);
      checkOutput("clear vs underflow ctrl", data_out, 16'h000D);
      checkOutput("irq stays high", {15'b0, interrupt}, 16'h0001);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/reflet_timer.md
Name: reflet_timer

Overview:
- Memory-mapped countdown timer for the reflet CPU data bus.
- Sits beside RAM/ROM on the address-decoded bus and consumes CPU bus transactions.
- Drives one bit of the CPU `ext_int` vector, so it also acts as an upstream interrupt source.
- Read data is zero when not selected, so it can be OR-combined onto the shared CPU `data_in` bus.

Parameters:
- wordsize, 16, data bus width; must be at least 8. All registers are wordsize bits.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state
- enable  input  1  chip select from the system address decoder
- addr  input  2  register index
- data_in  input  wordsize  CPU write data
- write_en  input  1  CPU write strobe; acts only when enable=1
- data_out  output  wordsize  registered read data
- interrupt  output  1  level interrupt request to CPU `ext_int`

Behaviour:
- Register map (addr):
  - 0 CTRL:
    - bit0 RUN
    - bit1 AUTO_RELOAD
    - bit2 IRQ_EN
    - bit3 PENDING (read; write 1 clears, write 0 no effect)
    - other bits read 0
  - 1 PRESCALE
  - 2 RELOAD
  - 3 COUNT (read current value; write loads directly)
- Writes: occur on the clock edge where enable=1 and write_en=1.
- Reads:
  - data_out is valid the cycle after enable=1 with write_en=0.
  - data_out is 0 the cycle after enable=0 or after a write cycle.
- Reset: on any clk edge with reset=1, all of the following are 0 in the next cycle:
  - CTRL, PRESCALE, RELOAD, COUNT
  - the internal prescale counter pcnt
  - data_out and interrupt
- Reset mid-count abandons the count with no interrupt.
- Prescaler:
  - While RUN=1, pcnt counts from 0 to PRESCALE.
  - On the cycle pcnt==PRESCALE, a tick is generated and pcnt returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - While RUN=0, pcnt holds at 0 and no ticks occur.
- On tick:
  - COUNT!=0: COUNT <= COUNT-1.
  - COUNT==0: PENDING <= 1. Then:
    - AUTO_RELOAD=1: COUNT <= RELOAD.
    - AUTO_RELOAD=0: RUN <= 0 and COUNT stays 0 (one-shot).
- Period: in auto-reload mode, underflow events are (RELOAD+1)*(PRESCALE+1) cycles apart.
- Interrupt: interrupt = PENDING & IRQ_EN, registered with the state, not a pulse.
- Writing RUN 0->1 clears pcnt to 0. The first tick arrives PRESCALE+1 cycles later.
- Simultaneous events:
  - CPU write to COUNT on a tick cycle: the written value wins and the decrement is lost.
  - CPU write to CTRL on a tick cycle: CPU bits win, except PENDING, where a set by underflow beats a write-1-clear in the same cycle.
  - Underflow in one-shot mode on the same cycle as a CPU write setting RUN=1: the CPU write wins (RUN stays 1).
- Arithmetic:
  - Unsigned, wordsize bits.
  - COUNT never wraps below 0; the 0 state is the underflow event.
  - All 2^wordsize values of PRESCALE and RELOAD are legal.
- No combinational path from bus inputs to data_out or interrupt.

Test Plan:
- Reset: apply reset=1 for 2 cycles after arbitrary writes -> all four registers read 0; interrupt=0; data_out=0.
- Read latency and bus isolation:
  - write RELOAD=0x1234, then read addr 2 -> data_out=0x1234 exactly one cycle after the read.
  - with enable=0 -> data_out=0x0000.
- One-shot:
  - setup: PRESCALE=0, COUNT=3, CTRL=0x5 (RUN, IRQ_EN).
  - interrupt rises 4 cycles after the write.
  - RUN reads 0 afterwards; COUNT=0.
  - writing CTRL bit3=1 drops interrupt the next cycle.
- Auto-reload with prescaler:
  - setup: PRESCALE=2, RELOAD=4, CTRL=0x3.
  - PENDING sets every 15 cycles.
  - interrupt stays 0 because IRQ_EN=0.
- Collision, COUNT write vs tick: with PRESCALE=0, write COUNT=7 on a tick cycle -> next read returns 7, not 6.
- Collision, PENDING clear vs underflow: write-1-clear of PENDING on the underflow cycle -> PENDING=1 and interrupt stays high.
